// File: rtl/adc_scan_sequencer_if.sv
// rtl/adc_scan_sequencer_if.sv - handshake bundle between the scan sequencer and the LTC2308 driver
interface adc_scan_sequencer_if;
  logic        adc_start;
  logic [2:0]  adc_ch;
  logic        adc_done;
  logic [11:0] adc_data;

  modport master (output adc_start, output adc_ch, input adc_done, input adc_data);
  modport slave  (input adc_start, input adc_ch, output adc_done, output adc_data);
endinterface

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - channel-mask scan scheduler with per-channel result bank
// ADC_SCAN_AVG_EN: when defined, each channel is converted 4 times and the truncated mean is stored.
module adc_scan_sequencer #(
  parameter int PERIOD_W    = 16,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                trigger,
  input  logic [7:0]          ch_mask,
  input  logic [PERIOD_W-1:0] period,
  adc_scan_sequencer_if.master adc,
  input  logic [2:0]          rd_ch,
  output logic [11:0]         rd_data,
  output logic [7:0]          valid_mask,
  output logic                busy,
  output logic                scan_done,
  output logic                timeout_err,
  input  logic                err_clr
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_START, S_WAIT_LOW, S_WAIT_DONE, S_STORE
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          scan_mask_q, scan_mask_d;
  logic [2:0]          cur_q, cur_d;
  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [11:0]         data_q, data_d;
  logic                abort_q, abort_d;
  logic [7:0]          valid_q, valid_d;
  logic                err_q, err_d;
  logic [11:0]         bank_q [8];
`ifdef ADC_SCAN_AVG_EN
  logic [1:0]          rep_q, rep_d;
  logic [13:0]         sum_q, sum_d;
  logic [13:0]         sum_acc;
`endif

  logic                bank_we;
  logic [11:0]         bank_wdata;
  logic                scan_done_c;
  logic                advance;
  logic                timeout_hit;
  logic [2:0]          first_cur;
  logic [2:0]          nxt_cur;
  logic                nxt_found;

  // Lowest set bit of the incoming mask, and lowest set bit of the latched mask above cur.
  always_comb begin
    first_cur = '0;
    nxt_cur   = cur_q;
    nxt_found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (ch_mask[i]) first_cur = 3'(i);
      if (scan_mask_q[i] && (3'(i) > cur_q)) begin
        nxt_cur   = 3'(i);
        nxt_found = 1'b1;
      end
    end
  end

  assign timeout_hit = ((state_q == S_WAIT_LOW) || (state_q == S_WAIT_DONE)) &&
                       (tmo_q == TW'(TIMEOUT_CYC));

  always_comb begin
    state_d     = state_q;
    scan_mask_d = scan_mask_q;
    cur_d       = cur_q;
    tmo_d       = tmo_q;
    data_d      = data_q;
    abort_d     = abort_q;
    valid_d     = valid_q;
    err_d       = err_q & ~err_clr;
    bank_we     = 1'b0;
    bank_wdata  = data_q;
    scan_done_c = 1'b0;
    advance     = 1'b0;
    per_cnt_d   = (per_cnt_q != '0) ? per_cnt_q - PERIOD_W'(1) : '0;
`ifdef ADC_SCAN_AVG_EN
    rep_d       = rep_q;
    sum_d       = sum_q;
    sum_acc     = sum_q + 14'(data_q);
`endif

    case (state_q)
      S_IDLE: begin
        // A count of 1 or less means the period elapses at the end of this cycle.
        if (trigger || (enable && (per_cnt_q <= PERIOD_W'(1)))) begin
          per_cnt_d   = period;
          scan_mask_d = ch_mask;
          if (ch_mask != 8'h00) begin
            cur_d   = first_cur;
            state_d = S_SELECT;
`ifdef ADC_SCAN_AVG_EN
            rep_d   = '0;
            sum_d   = '0;
`endif
          end
        end
      end
      S_SELECT: begin
        abort_d = 1'b0;
        state_d = S_START;
      end
      S_START: begin
        tmo_d   = TW'(1);
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        tmo_d = tmo_q + TW'(1);
        if (timeout_hit) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = S_STORE;
        end else if (!adc.adc_done) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        tmo_d = tmo_q + TW'(1);
        if (timeout_hit) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = S_STORE;
        end else if (adc.adc_done) begin
          data_d  = adc.adc_data;
          state_d = S_STORE;
        end
      end
      S_STORE: begin
`ifdef ADC_SCAN_AVG_EN
        if (abort_q || (rep_q == 2'd3)) begin
          if (!abort_q) begin
            bank_we          = 1'b1;
            bank_wdata       = sum_acc[13:2];
            valid_d[cur_q]   = 1'b1;
          end
          advance = 1'b1;
        end else begin
          rep_d   = rep_q + 2'd1;
          sum_d   = sum_acc;
          state_d = S_SELECT;
        end
`else
        if (!abort_q) begin
          bank_we        = 1'b1;
          valid_d[cur_q] = 1'b1;
        end
        advance = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
`ifdef ADC_SCAN_AVG_EN
      rep_d = '0;
      sum_d = '0;
`endif
      if (nxt_found) begin
        cur_d   = nxt_cur;
        state_d = S_SELECT;
      end else begin
        scan_done_c = 1'b1;
        state_d     = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      scan_mask_q <= '0;
      cur_q       <= '0;
      per_cnt_q   <= '0;
      tmo_q       <= '0;
      data_q      <= '0;
      abort_q     <= 1'b0;
      valid_q     <= '0;
      err_q       <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
      rep_q       <= '0;
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      scan_mask_q <= scan_mask_d;
      cur_q       <= cur_d;
      per_cnt_q   <= per_cnt_d;
      tmo_q       <= tmo_d;
      data_q      <= data_d;
      abort_q     <= abort_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
`ifdef ADC_SCAN_AVG_EN
      rep_q       <= rep_d;
      sum_q       <= sum_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) bank_q[i] <= '0;
    end else if (bank_we) begin
      bank_q[cur_q] <= bank_wdata;
    end
  end

  // cur only moves in IDLE (no conversion) and on STORE exit, so adc_ch is stable per conversion.
  assign adc.adc_start = (state_q == S_START);
  assign adc.adc_ch    = cur_q;
  assign rd_data       = bank_q[rd_ch];
  assign valid_mask    = valid_q;
  assign busy          = (state_q != S_IDLE);
  assign scan_done     = scan_done_c;
  assign timeout_err   = err_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb/tb_adc_scan_sequencer.sv - directed self-checking bench for adc_scan_sequencer
module tb_adc_scan_sequencer;

`ifdef ADC_SCAN_AVG_EN
  localparam int REPS  = 4;
  localparam int LAT_C = 95;
`else
  localparam int REPS  = 1;
  localparam int LAT_C = 390;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        trigger = 1'b0;
  logic        err_clr = 1'b0;
  logic [7:0]  ch_mask = 8'h00;
  logic [15:0] period = 16'd0;
  logic [2:0]  rd_ch = 3'd0;
  logic [11:0] rd_data;
  logic [7:0]  valid_mask;
  logic        busy;
  logic        scan_done;
  logic        timeout_err;

  adc_scan_sequencer_if adc_if();

  adc_scan_sequencer u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .trigger     (trigger),
    .ch_mask     (ch_mask),
    .period      (period),
    .adc         (adc_if),
    .rd_ch       (rd_ch),
    .rd_data     (rd_data),
    .valid_mask  (valid_mask),
    .busy        (busy),
    .scan_done   (scan_done),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lat = 5;
  int          hang_ch = 8;
  int          cnt = 0;
  int          mch = 0;
  int          starts = 0;
  int          start_cyc = 0;
  int          ch_log [64];
  int          done_cnt = 0;
  bit          busy_seen = 1'b0;
  logic        busy_prev = 1'b0;
  int          rise_cyc [32];
  int          rises = 0;
  int          idle_run = 0;
  int          last_idle = 0;
  logic        err_prev = 1'b0;
  int          err_cyc = 0;
  logic [11:0] val [8];
  logic [11:0] seq [4];
  bit          use_seq = 1'b0;
  int          seq_idx = 0;

  // Driver model plus monitors, evaluated just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!reset_n) begin
      cnt = 0;
      adc_if.adc_done = 1'b1;
    end else if (adc_if.adc_start) begin
      adc_if.adc_done = 1'b0;
      cnt = lat;
      mch = int'(adc_if.adc_ch);
      if (starts < 64) ch_log[starts] = mch;
      starts++;
      start_cyc = cyc;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0 && mch != hang_ch) begin
        adc_if.adc_data = use_seq ? seq[seq_idx % 4] : val[mch];
        seq_idx++;
        adc_if.adc_done = 1'b1;
      end
    end
    if (scan_done) done_cnt++;
    if (busy) busy_seen = 1'b1;
    if (busy && !busy_prev) begin
      if (rises < 32) rise_cyc[rises] = cyc;
      rises++;
      last_idle = idle_run;
    end
    idle_run  = busy ? 0 : idle_run + 1;
    busy_prev = busy;
    if (timeout_err && !err_prev) err_cyc = cyc;
    err_prev = timeout_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bank(input string tag, input int ch, input logic [11:0] exp);
    rd_ch = 3'(ch);
    #1;
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
  endtask

  int s0;
  int d0;
  int r0;

  initial begin
    for (int i = 0; i < 8; i++) val[i] = 12'h000;
    val[0] = 12'h100;
    val[2] = 12'h200;
    val[7] = 12'h7FF;

    repeat (3) @(negedge clk);
    check("rst_adc_start", 32'(adc_if.adc_start), 0);
    check("rst_adc_ch", 32'(adc_if.adc_ch), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(valid_mask), 0);
    check("rst_err", 32'(timeout_err), 0);
    check("rst_scan_done", 32'(scan_done), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single scan over ch0/2/7.
    ch_mask = 8'h85;
    lat = 5;
    s0 = starts;
    d0 = done_cnt;
    pulse_trigger();
    check("sel_busy", 32'(busy), 1);
    check("sel_no_start", 32'(adc_if.adc_start), 0);
    @(negedge clk);
    check("start_t2", 32'(adc_if.adc_start), 1);
    check("start_ch", 32'(adc_if.adc_ch), 0);
    wait_idle(500);
    check("scan1_idle", 32'(busy), 0);
    check("scan1_starts", 32'(starts - s0), 32'(3 * REPS));
    check("scan1_ch_a", 32'(ch_log[s0]), 0);
    check("scan1_ch_b", 32'(ch_log[s0 + REPS]), 2);
    check("scan1_ch_c", 32'(ch_log[s0 + 2 * REPS]), 7);
    check("scan1_valid", 32'(valid_mask), 32'h85);
    check("scan1_done", 32'(done_cnt - d0), 1);
    check_bank("bank0", 0, 12'h100);
    check_bank("bank2", 2, 12'h200);
    check_bank("bank7", 7, 12'h7FF);
    check_bank("bank1_empty", 1, 12'h000);

    // Empty mask: nothing happens.
    ch_mask = 8'h00;
    busy_seen = 1'b0;
    s0 = starts;
    d0 = done_cnt;
    pulse_trigger();
    repeat (5) @(negedge clk);
    check("mask0_starts", 32'(starts - s0), 0);
    check("mask0_busy", 32'(busy_seen), 0);
    check("mask0_done", 32'(done_cnt - d0), 0);

    // Continuous scanning, period longer than the scan.
    ch_mask = 8'h07;
    lat = LAT_C;
    period = 16'd2000;
    r0 = rises;
    enable = 1'b1;
    for (int i = 0; i < 8000 && rises < r0 + 3; i++) @(negedge clk);
    check("cont_three_scans", 32'(rises >= r0 + 3), 1);
    check("cont_gap_a", 32'(rise_cyc[r0 + 1] - rise_cyc[r0]), 2000);
    check("cont_gap_b", 32'(rise_cyc[r0 + 2] - rise_cyc[r0 + 1]), 2000);
    period = 16'd10;
    for (int i = 0; i < 8000 && rises < r0 + 5; i++) @(negedge clk);
    check("b2b_scans", 32'(rises >= r0 + 5), 1);
    check("b2b_idle_len", 32'(last_idle), 1);
    enable = 1'b0;
    wait_idle(3000);
    check("cont_stop", 32'(busy), 0);
    check("cont_no_err", 32'(timeout_err), 0);

    // Hung conversion on ch3.
    lat = 5;
    hang_ch = 3;
    val[2] = 12'h2AB;
    val[3] = 12'h333;
    ch_mask = 8'h0C;
    pulse_trigger();
    wait_idle(6000);
    check("tmo_idle", 32'(busy), 0);
    check("tmo_err", 32'(timeout_err), 1);
    check("tmo_cycles", 32'(err_cyc - start_cyc), 1024);
    check("tmo_valid3", 32'(valid_mask[3]), 0);
    check_bank("tmo_bank3", 3, 12'h000);
    check_bank("tmo_bank2", 2, 12'h2AB);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", 32'(timeout_err), 0);
    hang_ch = 8;

    // Reset in the middle of a conversion.
    ch_mask = 8'h02;
    lat = 20;
    val[1] = 12'h5A5;
    pulse_trigger();
    repeat (8) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_valid", 32'(valid_mask), 0);
    check("mid_rst_start", 32'(adc_if.adc_start), 0);
    check("mid_rst_ch", 32'(adc_if.adc_ch), 0);
    check("mid_rst_err", 32'(timeout_err), 0);
    check("mid_rst_done", 32'(scan_done), 0);
    check_bank("mid_rst_bank2", 2, 12'h000);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    s0 = starts;
    pulse_trigger();
    wait_idle(500);
    check("post_rst_idle", 32'(busy), 0);
    check("post_rst_starts", 32'(starts - s0), 32'(REPS));
    check("post_rst_valid", 32'(valid_mask), 32'h02);
    check_bank("post_rst_bank1", 1, 12'h5A5);

`ifdef ADC_SCAN_AVG_EN
    // Averaging: 100,101,102,104 sums to 407, stored as 101.
    seq[0] = 12'd100;
    seq[1] = 12'd101;
    seq[2] = 12'd102;
    seq[3] = 12'd104;
    seq_idx = 0;
    use_seq = 1'b1;
    lat = 5;
    s0 = starts;
    pulse_trigger();
    wait_idle(500);
    use_seq = 1'b0;
    check("avg_starts", 32'(starts - s0), 4);
    check("avg_ch", 32'(ch_log[s0 + 3]), 1);
    check_bank("avg_bank1", 1, 12'd101);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Scan scheduler in front of the LTC2308 driver (`adc_ltc2308`). Walks an enabled-channel mask, issues one `measure_start` rising edge per conversion, waits for `measure_done`, and stores each 12-bit result in a per-channel result bank. The bank is read by the game-logic modules. Supports single-shot and periodic continuous scanning, with a conversion timeout for a hung ADC path.

## Interface
- `PERIOD_W`, 16: width of scan period counter.
- `TIMEOUT_CYC`, 1023: max cycles from `adc_start` to `adc_done` before abort.
- `clk` in 1: system clock (≤40 MHz, same clock as ADC driver).
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: continuous scanning enabled.
- `trigger` in 1: one-cycle pulse; starts a single scan when idle.
- `ch_mask` in 8: channel enable, bit n = channel n.
- `period` in PERIOD_W: cycles between scan starts in continuous mode.
- `adc_start` out 1: to driver `measure_start`.
- `adc_ch` out 3: to driver `measure_ch`.
- `adc_done` in 1: from driver `measure_done`.
- `adc_data` in 12: from driver `measured_data`.
- `rd_ch` in 3: result bank read address.
- `rd_data` out 12: combinational read of bank[`rd_ch`].
- `valid_mask` out 8: bit n set once channel n holds a result.
- `busy` out 1: scan in progress.
- `scan_done` out 1: one-cycle pulse at end of each scan.
- `timeout_err` out 1: sticky; set on conversion timeout.
- `err_clr` in 1: clears `timeout_err`.

## Operation
- Reset values: `adc_start`=0, `adc_ch`=0, bank all 0, `valid_mask`=0, `busy`=0, `scan_done`=0, `timeout_err`=0, period counter=0, state IDLE.
- States:
  - IDLE → SELECT on `trigger` or (`enable` and period counter expired). Latches `ch_mask` into `scan_mask` and sets `cur` = lowest set bit. If the latched mask is 0, stay IDLE with no `scan_done`.
  - SELECT: drive `adc_ch`=`cur` → START.
  - START: `adc_start`=1 for exactly one cycle → WAIT_LOW.
  - WAIT_LOW: wait until `adc_done`=0, since the driver clears done on the start edge → WAIT_DONE.
  - WAIT_DONE: on `adc_done`=1 → STORE.
  - STORE: write bank[`cur`] and set `valid_mask[cur]`. If a higher set bit exists in `scan_mask`, set `cur` to it → SELECT. Otherwise pulse `scan_done` → IDLE.
- Timeout: a counter runs from START. When it reaches `TIMEOUT_CYC` in WAIT_LOW/WAIT_DONE, set `timeout_err`, do not write bank[`cur`], and continue with the next channel as STORE would.
- `adc_ch` holds stable from SELECT through STORE. `adc_start` is 0 in every other state.
- Period counter: reloads to `period` on each scan start and decrements to 0 independent of the scan.
  - Scan longer than the period: the next scan starts the cycle after return to IDLE.
  - `period`=0: back-to-back scans.
- `trigger` while `busy` is ignored. `enable` falling mid-scan finishes the current scan, then idles.
- `ch_mask` changes mid-scan take effect at the next scan.
- `err_clr` and a simultaneous timeout: set wins.
- Async reset mid-conversion: returns to IDLE. The driver's pending done is discarded by the WAIT_LOW requirement on the next scan.

## Timing
- `trigger` at cycle T: SELECT at T+1, `adc_start` high at T+2.
- `adc_done` rising sampled at cycle D: bank and `valid_mask` update at D+2 (WAIT_DONE→STORE, write on STORE exit edge). `rd_data` reflects the new value the same cycle.
- Inter-conversion overhead: 4 cycles (STORE, SELECT, START, WAIT_LOW minimum).
- `scan_done` is asserted during the final STORE cycle. `busy` is high from SELECT through that STORE.

## Configuration
- `ADC_SCAN_AVG_EN` defined:
  - Each channel is converted 4 times consecutively (SELECT→…→STORE repeated, `cur` unchanged).
  - Samples accumulate in a 14-bit sum; the bank gets `sum[13:2]` (truncating) after the 4th.
  - A timeout on any of the 4 conversions discards that channel's average.
- Not defined: single conversion per channel, raw `adc_data` stored.

## Test plan
- Single scan: `ch_mask`=8'b1000_0101, `trigger`, model returns 0x100/0x200/0x7FF for ch0/2/7.
  - Required: `adc_ch` sequence 0,2,7.
  - Required: exactly 3 `adc_start` pulses.
  - Required: `valid_mask`=8'h85 and bank values match.
  - Required: one `scan_done`.
- Mask 0 with `trigger`: no `adc_start`, `busy` stays 0, no `scan_done`.
- Continuous with `period`=2000 and scan length ≈1200: scan starts are 2000 cycles apart.
  - Then `period`=10: scans run back-to-back with 1-cycle IDLE.
- Model never raises `adc_done` on ch3 (mask 8'h0C):
  - Required: `timeout_err`=1 after 1023 cycles, bank[3] unchanged, ch2 still stored.
  - Required: `err_clr` clears the error.
- Asserting `reset_n` during WAIT_DONE: all outputs return to reset values. A subsequent trigger completes correctly with the model holding stale `adc_done`=1.
- With `ADC_SCAN_AVG_EN`, ch1 samples 100,101,102,104 (sum 407):
  - Required: bank[1]=101.
  - Required: 4 `adc_start` pulses on ch1.
